// File: rtl/boa_extram_arbiter.sv
// boa_extram_arbiter: shares the single external SRAM controller port between
// two masters (port 0 = CPU extram bus, port 1 = secondary master such as DMA).
// Round-robin arbitration (or fixed priority to port 0); an owner is held until
// s_ready or until it withdraws its request.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mN_re/we/addr/wdata        request from master N (held until mN_ready)
//   mN_rdata, mN_ready         read data broadcast, completion gated to owner
//   s_re/we/addr/wdata         request mirrored from the current owner (0 if idle)
//   s_rdata, s_ready           controller response
//   grant                      registered one-hot owner, 00 when idle
module boa_extram_arbiter #(
  parameter int unsigned alen       = 19,
  parameter bit          fixed_prio = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_re,
  input  logic [3:0]      m0_we,
  input  logic [alen-1:0] m0_addr,
  input  logic [31:0]     m0_wdata,
  output logic [31:0]     m0_rdata,
  output logic            m0_ready,
  input  logic            m1_re,
  input  logic [3:0]      m1_we,
  input  logic [alen-1:0] m1_addr,
  input  logic [31:0]     m1_wdata,
  output logic [31:0]     m1_rdata,
  output logic            m1_ready,
  output logic            s_re,
  output logic [3:0]      s_we,
  output logic [alen-1:0] s_addr,
  output logic [31:0]     s_wdata,
  input  logic [31:0]     s_rdata,
  input  logic            s_ready,
  output logic [1:0]      grant
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BUSY0 = 2'b01,
    ST_BUSY1 = 2'b10
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_last;      // port that completed most recently
  logic       w_last_nxt;
  logic [1:0] r_grant;
  logic       w_m0_pend;
  logic       w_m1_pend;

  assign w_m0_pend = m0_re | (|m0_we);
  assign w_m1_pend = m1_re | (|m1_we);

  // Read data is broadcast; only the ready gating selects the consumer.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign grant    = r_grant;

  // Next-state, slave mux and ready gating.
  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    s_re        = 1'b0;
    s_we        = 4'b0000;
    s_addr      = '0;
    s_wdata     = 32'd0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_m0_pend && w_m1_pend) begin
          // r_last==1 means port 1 went last, so port 0 wins the tie.
          w_state_nxt = (fixed_prio || r_last) ? ST_BUSY0 : ST_BUSY1;
        end else if (w_m0_pend) begin
          w_state_nxt = ST_BUSY0;
        end else if (w_m1_pend) begin
          w_state_nxt = ST_BUSY1;
        end
      end
      ST_BUSY0: begin
        s_re     = m0_re;
        s_we     = m0_we;
        s_addr   = m0_addr;
        s_wdata  = m0_wdata;
        m0_ready = s_ready;
        if (s_ready) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b0;
        end else if (!w_m0_pend) begin
          // Withdrawn without completion: release, keep fairness history.
          w_state_nxt = ST_IDLE;
        end
      end
      ST_BUSY1: begin
        s_re     = m1_re;
        s_we     = m1_we;
        s_addr   = m1_addr;
        s_wdata  = m1_wdata;
        m1_ready = s_ready;
        if (s_ready) begin
          w_state_nxt = ST_IDLE;
          w_last_nxt  = 1'b1;
        end else if (!w_m1_pend) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, fairness history and grant register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_grant <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_grant <= {w_state_nxt == ST_BUSY1, w_state_nxt == ST_BUSY0};
    end
  end

endmodule

// File: tb/tb_boa_extram_arbiter.sv
// Bench for boa_extram_arbiter: a round-robin instance and a fixed-priority
// instance share the same stimulus; each is compared every cycle against an
// owner/last model, with directed scenarios pinned by literal expectations.
module tb_boa_extram_arbiter;

  localparam int unsigned ALEN = 19;

  logic            clk;
  logic            rst_n;
  logic            m_re    [2];
  logic [3:0]      m_we    [2];
  logic [ALEN-1:0] m_addr  [2];
  logic [31:0]     m_wdata [2];
  logic            s_ready;
  logic [31:0]     s_rdata;

  logic            d_s_re    [2];
  logic [3:0]      d_s_we    [2];
  logic [ALEN-1:0] d_s_addr  [2];
  logic [31:0]     d_s_wdata [2];
  logic            d_rdy0    [2];
  logic            d_rdy1    [2];
  logic [31:0]     d_rd0     [2];
  logic [31:0]     d_rd1     [2];
  logic [1:0]      d_grant   [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    boa_extram_arbiter #(.alen(ALEN), .fixed_prio(g == 1)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .m0_re    (m_re[0]),
      .m0_we    (m_we[0]),
      .m0_addr  (m_addr[0]),
      .m0_wdata (m_wdata[0]),
      .m0_rdata (d_rd0[g]),
      .m0_ready (d_rdy0[g]),
      .m1_re    (m_re[1]),
      .m1_we    (m_we[1]),
      .m1_addr  (m_addr[1]),
      .m1_wdata (m_wdata[1]),
      .m1_rdata (d_rd1[g]),
      .m1_ready (d_rdy1[g]),
      .s_re     (d_s_re[g]),
      .s_we     (d_s_we[g]),
      .s_addr   (d_s_addr[g]),
      .s_wdata  (d_s_wdata[g]),
      .s_rdata  (s_rdata),
      .s_ready  (s_ready),
      .grant    (d_grant[g])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_fail = 0;

  // Model: current owner (-1 = nobody) and last completed port, per instance.
  int own [2];
  int lst [2];
  bit e_rdy [2][2];
  logic [1:0] pg [2];
  logic [1:0] dlog0 [$];
  logic [1:0] dlog1 [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare both instances against the model at the falling edge.
  task automatic sample();
    logic            x_re;
    logic [3:0]      x_we;
    logic [ALEN-1:0] x_addr;
    logic [31:0]     x_wd;
    logic [1:0]      x_g;
    int p;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        own[k] = -1;
        lst[k] = 1;
      end
      p = own[k];
      x_re = 1'b0; x_we = 4'd0; x_addr = '0; x_wd = 32'd0; x_g = 2'b00;
      if (p >= 0) begin
        x_re = m_re[p]; x_we = m_we[p]; x_addr = m_addr[p]; x_wd = m_wdata[p];
        x_g  = (p == 0) ? 2'b01 : 2'b10;
      end
      e_rdy[k][0] = (p == 0) && s_ready;
      e_rdy[k][1] = (p == 1) && s_ready;
      chk($sformatf("s_re[%0d]", k),    64'(d_s_re[k]),    64'(x_re));
      chk($sformatf("s_we[%0d]", k),    64'(d_s_we[k]),    64'(x_we));
      chk($sformatf("s_addr[%0d]", k),  64'(d_s_addr[k]),  64'(x_addr));
      chk($sformatf("s_wdata[%0d]", k), 64'(d_s_wdata[k]), 64'(x_wd));
      chk($sformatf("m0_ready[%0d]", k), 64'(d_rdy0[k]), 64'(e_rdy[k][0]));
      chk($sformatf("m1_ready[%0d]", k), 64'(d_rdy1[k]), 64'(e_rdy[k][1]));
      chk($sformatf("m0_rdata[%0d]", k), 64'(d_rd0[k]), 64'(s_rdata));
      chk($sformatf("m1_rdata[%0d]", k), 64'(d_rd1[k]), 64'(s_rdata));
      chk($sformatf("grant[%0d]", k),    64'(d_grant[k]), 64'(x_g));
      if (d_grant[k] != 2'b00 && pg[k] == 2'b00) begin
        if (k == 0) dlog0.push_back(d_grant[k]);
        else        dlog1.push_back(d_grant[k]);
      end
      pg[k] = d_grant[k];
    end
  endtask

  // Advance the model with the current inputs, then move to posedge+1.
  task automatic advance();
    bit pd [2];
    int p;
    pd[0] = m_re[0] | (|m_we[0]);
    pd[1] = m_re[1] | (|m_we[1]);
    for (int k = 0; k < 2; k++) begin
      p = own[k];
      if (!rst_n) begin
        own[k] = -1;
        lst[k] = 1;
      end else if (p < 0) begin
        if (pd[0] && pd[1]) own[k] = (k == 1 || lst[k] == 1) ? 0 : 1;
        else if (pd[0])     own[k] = 0;
        else if (pd[1])     own[k] = 1;
      end else if (s_ready) begin
        lst[k] = p;
        own[k] = -1;
      end else if (!pd[p]) begin
        own[k] = -1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic clr_inputs();
    for (int p = 0; p < 2; p++) begin
      m_re[p] = 1'b0; m_we[p] = 4'd0; m_addr[p] = '0; m_wdata[p] = 32'd0;
    end
    s_ready = 1'b0;
    s_rdata = 32'd0;
  endtask

  // First eight logged grants of instance k, 2'b11 marking missing entries.
  function automatic logic [15:0] pack8(input int k);
    logic [15:0] v;
    v = 16'hFFFF;
    for (int i = 0; i < 8; i++) begin
      if (k == 0 && i < dlog0.size()) v[2*i +: 2] = dlog0[i];
      if (k == 1 && i < dlog1.size()) v[2*i +: 2] = dlog1[i];
    end
    return v;
  endfunction

  initial begin
    bit              act [2];
    logic            nre [2];
    logic [3:0]      nwe [2];
    logic [ALEN-1:0] nad [2];
    logic [31:0]     nwd [2];
    int kind;

    for (int k = 0; k < 2; k++) begin
      own[k] = -1; lst[k] = 1; pg[k] = 2'b00;
    end
    rst_n = 1'b0;
    clr_inputs();
    cyc(2);
    rst_n = 1'b1;

    // Single read on port 0, slave answers 3 cycles after s_re.
    m_re[0] = 1'b1; m_addr[0] = ALEN'(32'h100);
    sample(); chk("t1 s_re before grant", 64'(d_s_re[0]), 64'd0); advance();
    sample();
    chk("t1 s_re", 64'(d_s_re[0]), 64'd1);
    chk("t1 s_addr", 64'(d_s_addr[0]), 64'h100);
    chk("t1 grant", 64'(d_grant[0]), 64'h1);
    advance();
    cyc(2);
    s_ready = 1'b1; s_rdata = 32'hDEADBEEF;
    sample();
    chk("t1 m0_ready", 64'(d_rdy0[0]), 64'd1);
    chk("t1 m0_rdata", 64'(d_rd0[0]), 64'hDEADBEEF);
    chk("t1 m1_ready", 64'(d_rdy1[0]), 64'd0);
    advance();
    clr_inputs();
    cyc(1);

    // Simultaneous requests right after reset: port 0 first.
    rst_n = 1'b0; sample(); advance(); rst_n = 1'b1;
    m_we[0] = 4'hF; m_addr[0] = ALEN'(32'h10); m_wdata[0] = 32'h11223344;
    m_re[1] = 1'b1; m_addr[1] = ALEN'(32'h20);
    sample(); chk("t2 idle grant", 64'(d_grant[0]), 64'd0); advance();
    s_ready = 1'b1;
    sample();
    chk("t2 grant p0", 64'(d_grant[0]), 64'h1);
    chk("t2 s_we", 64'(d_s_we[0]), 64'hF);
    chk("t2 s_addr", 64'(d_s_addr[0]), 64'h10);
    chk("t2 s_wdata", 64'(d_s_wdata[0]), 64'h11223344);
    chk("t2 m0_ready", 64'(d_rdy0[0]), 64'd1);
    advance();
    m_we[0] = 4'd0; s_ready = 1'b0;
    sample();
    chk("t2 gap s_re", 64'(d_s_re[0]), 64'd0);
    chk("t2 gap grant", 64'(d_grant[0]), 64'd0);
    advance();
    s_ready = 1'b1;
    sample();
    chk("t2 p1 s_addr", 64'(d_s_addr[0]), 64'h20);
    chk("t2 p1 grant", 64'(d_grant[0]), 64'h2);
    chk("t2 p1 ready", 64'(d_rdy1[0]), 64'd1);
    advance();
    clr_inputs();

    // Continuous contention with 1-cycle ready.
    dlog0.delete(); dlog1.delete();
    m_re[0] = 1'b1; m_addr[0] = ALEN'(32'h400);
    m_re[1] = 1'b1; m_addr[1] = ALEN'(32'h800);
    s_ready = 1'b1;
    cyc(24);
    chk("t3 rr grant order", 64'(pack8(0)), 64'h9999);
    chk("t3 fixed grant order", 64'(pack8(1)), 64'h5555);
    m_re[0] = 1'b0;
    dlog0.delete(); dlog1.delete();
    cyc(6);
    chk("t3 fixed p1 when p0 idle", 64'((dlog1.size() > 0) ? dlog1[0] : 2'b00), 64'h2);
    clr_inputs();
    cyc(2);

    // Reset while port 1 owns the slave.
    m_re[1] = 1'b1; m_addr[1] = ALEN'(32'h40);
    cyc(1);
    sample(); chk("t4 busy1 grant", 64'(d_grant[0]), 64'h2); advance();
    rst_n = 1'b0; s_ready = 1'b1;
    sample();
    chk("t4 rst s_re", 64'(d_s_re[0]), 64'd0);
    chk("t4 rst m1_ready", 64'(d_rdy1[0]), 64'd0);
    chk("t4 rst grant", 64'(d_grant[0]), 64'd0);
    advance();
    rst_n = 1'b1; s_ready = 1'b0; m_re[0] = 1'b1; m_addr[0] = ALEN'(32'h44);
    cyc(1);
    sample(); chk("t4 tie after reset", 64'(d_grant[0]), 64'h1); advance();

    // Withdrawal by port 1; last must still point at port 0.
    s_ready = 1'b1;
    cyc(1);
    m_re[0] = 1'b0; s_ready = 1'b0;
    cyc(1);
    sample(); chk("t5 busy1 grant", 64'(d_grant[0]), 64'h2); advance();
    m_re[1] = 1'b0;
    sample();
    chk("t5 withdraw s_re", 64'(d_s_re[0]), 64'd0);
    chk("t5 withdraw ready", 64'(d_rdy1[0]), 64'd0);
    advance();
    m_re[0] = 1'b1; m_re[1] = 1'b1;
    sample(); chk("t5 idle grant", 64'(d_grant[0]), 64'd0); advance();
    sample(); chk("t5 last unchanged", 64'(d_grant[0]), 64'h2); advance();
    clr_inputs();
    cyc(3);

    // Randomized masters, slave and occasional resets.
    act[0] = 1'b0; act[1] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      sample();
      for (int p = 0; p < 2; p++) begin
        nre[p] = m_re[p]; nwe[p] = m_we[p]; nad[p] = m_addr[p]; nwd[p] = m_wdata[p];
        if (act[p]) begin
          if (e_rdy[0][p] || $urandom_range(0, 39) == 0) begin
            act[p] = 1'b0; nre[p] = 1'b0; nwe[p] = 4'd0;
          end
        end else if ($urandom_range(0, 2) == 0) begin
          act[p] = 1'b1;
          kind   = int'($urandom_range(0, 2));
          nre[p] = (kind != 1);
          nwe[p] = (kind == 0) ? 4'd0 : 4'($urandom_range(1, 15));
          nad[p] = ALEN'($urandom);
          nwd[p] = $urandom;
        end else begin
          nad[p] = ALEN'($urandom);
          nwd[p] = $urandom;
        end
      end
      advance();
      for (int p = 0; p < 2; p++) begin
        m_re[p] = nre[p]; m_we[p] = nwe[p]; m_addr[p] = nad[p]; m_wdata[p] = nwd[p];
      end
      s_ready = (own[0] >= 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
      s_rdata = $urandom;
      rst_n   = ($urandom_range(0, 399) != 0);
    end
    rst_n = 1'b1;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
